// File: rtl/painterengine_gpu_blit_scheduler_if.sv
// Bus bundle between the blit scheduler and its environment: job
// configuration and control, reader/writer burst handshakes, FIFO resets
// and status. The master side is the scheduler itself.
interface painterengine_gpu_blit_scheduler_if;
   logic        i_wire_start;
   logic        i_wire_abort;
   logic        i_wire_mode;
   logic [31:0] i_wire_src_frame_buffer_address;
   logic [31:0] i_wire_dst_frame_buffer_address;
   logic [31:0] i_wire_src_frame_buffer_width;
   logic [31:0] i_wire_dst_frame_buffer_width;
   logic [31:0] i_wire_render_frame_buffer_xcount;
   logic [31:0] i_wire_render_frame_buffer_ycount;
   logic        i_wire_reader_done;
   logic        i_wire_reader_error;
   logic        i_wire_writer_done;
   logic        i_wire_writer_error;
   logic [31:0] o_wire_reader_address;
   logic [31:0] o_wire_reader_length;
   logic        o_wire_reader1_resetn;
   logic        o_wire_reader2_resetn;
   logic [31:0] o_wire_writer_address;
   logic [31:0] o_wire_writer_length;
   logic        o_wire_writer_resetn;
   logic        o_wire_fifo1_resetn;
   logic        o_wire_fifo2_resetn;
   logic        o_wire_busy;
   logic [31:0] o_wire_pixels_done;
   logic [31:0] o_wire_state;

   modport master (
      input  i_wire_start, i_wire_abort, i_wire_mode,
             i_wire_src_frame_buffer_address, i_wire_dst_frame_buffer_address,
             i_wire_src_frame_buffer_width, i_wire_dst_frame_buffer_width,
             i_wire_render_frame_buffer_xcount, i_wire_render_frame_buffer_ycount,
             i_wire_reader_done, i_wire_reader_error,
             i_wire_writer_done, i_wire_writer_error,
      output o_wire_reader_address, o_wire_reader_length,
             o_wire_reader1_resetn, o_wire_reader2_resetn,
             o_wire_writer_address, o_wire_writer_length, o_wire_writer_resetn,
             o_wire_fifo1_resetn, o_wire_fifo2_resetn,
             o_wire_busy, o_wire_pixels_done, o_wire_state
   );

   modport slave (
      output i_wire_start, i_wire_abort, i_wire_mode,
             i_wire_src_frame_buffer_address, i_wire_dst_frame_buffer_address,
             i_wire_src_frame_buffer_width, i_wire_dst_frame_buffer_width,
             i_wire_render_frame_buffer_xcount, i_wire_render_frame_buffer_ycount,
             i_wire_reader_done, i_wire_reader_error,
             i_wire_writer_done, i_wire_writer_error,
      input  o_wire_reader_address, o_wire_reader_length,
             o_wire_reader1_resetn, o_wire_reader2_resetn,
             o_wire_writer_address, o_wire_writer_length, o_wire_writer_resetn,
             o_wire_fifo1_resetn, o_wire_fifo2_resetn,
             o_wire_busy, o_wire_pixels_done, o_wire_state
   );
endinterface

// File: rtl/painterengine_gpu_blit_scheduler.sv
// Tile blit scheduler: walks an xcount*ycount rectangle row by row in bursts
// of up to BLOCK_PIXELS pixels. Each burst reads the source (and, in BLEND
// mode, the destination) through the shared reader, then runs the writer.
module painterengine_gpu_blit_scheduler #(
   parameter int BLOCK_PIXELS = 64,
   parameter int BPP_LOG2     = 2,
   parameter int COORD_WIDTH  = 16
) (
   input  logic i_wire_clock,
   input  logic i_wire_resetn,
   painterengine_gpu_blit_scheduler_if.master io_bus
);
   localparam int          CW       = COORD_WIDTH;
   localparam logic [31:0] LP_BLOCK = 32'(BLOCK_PIXELS);

   typedef enum logic [7:0] {
      S_CALC   = 8'h01, S_CALC2  = 8'h02, S_READ1 = 8'h03, S_READ2 = 8'h04,
      S_WRITE  = 8'h05, S_DONE   = 8'h06, S_R1_ERR = 8'h07, S_R2_ERR = 8'h08,
      S_W_ERR  = 8'h09, S_IDLE   = 8'h0A
   } state_t;

   state_t          r_state, w_state_next;
   logic            r_mode;
   logic [31:0]     r_src_base, r_dst_base;
   logic [CW-1:0]   r_src_stride, r_dst_stride, r_xcount, r_ycount, r_x, r_y;
   logic [31:0]     r_ys, r_yd, r_len;
   logic [31:0]     r_reader_address, r_reader_length;
   logic [31:0]     r_writer_address, r_writer_length, r_pixels_done;
   logic            r_reader1_resetn, r_reader2_resetn, r_writer_resetn;
   logic            r_fifo_resetn, r_fifo_pulse;

   logic            w_start_acc, w_row_next, w_calc_offs;
   logic            w_r1_done, w_r2_done, w_w_done, w_enter_write;
   logic [CW:0]     w_y_inc;
   logic [CW-1:0]   w_remain;
   logic [31:0]     w_len, w_x_off;
   logic            w_unused_bits;

   assign w_y_inc       = {1'b0, r_y} + {{CW{1'b0}}, 1'b1};
   assign w_remain      = r_xcount - r_x;
   assign w_len         = (32'(w_remain) > LP_BLOCK) ? LP_BLOCK : 32'(w_remain);
   assign w_x_off       = 32'(r_x) << BPP_LOG2;
   assign w_enter_write = (w_r1_done && !r_mode) || w_r2_done;
   assign w_unused_bits = ^{io_bus.i_wire_src_frame_buffer_width[31:CW],
                            io_bus.i_wire_dst_frame_buffer_width[31:CW],
                            io_bus.i_wire_render_frame_buffer_xcount[31:CW],
                            io_bus.i_wire_render_frame_buffer_ycount[31:CW]};

   // State register.
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) r_state <= S_IDLE;
      else                r_state <= w_state_next;
   end

   // Next-state decode; done/error only count while the matching enable is registered high.
   always_comb begin
      w_state_next = r_state;
      w_start_acc  = 1'b0;
      w_row_next   = 1'b0;
      w_calc_offs  = 1'b0;
      w_r1_done    = 1'b0;
      w_r2_done    = 1'b0;
      w_w_done     = 1'b0;
      if (io_bus.i_wire_abort) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_R1_ERR, S_R2_ERR, S_W_ERR: begin
               if (io_bus.i_wire_start) begin
                  w_start_acc  = 1'b1;
                  w_state_next = S_CALC;
               end
            end
            S_CALC: begin
               if (r_xcount == '0 || r_ycount == '0) begin
                  w_state_next = S_DONE;
               end else if (r_x == r_xcount) begin
                  if (w_y_inc >= {1'b0, r_ycount}) w_state_next = S_DONE;
                  else                             w_row_next   = 1'b1;
               end else begin
                  w_calc_offs  = 1'b1;
                  w_state_next = S_CALC2;
               end
            end
            S_CALC2: w_state_next = S_READ1;
            S_READ1: begin
               if (r_reader1_resetn) begin
                  if (io_bus.i_wire_reader_error) begin
                     w_state_next = S_R1_ERR;
                  end else if (io_bus.i_wire_reader_done) begin
                     w_r1_done    = 1'b1;
                     w_state_next = r_mode ? S_READ2 : S_WRITE;
                  end
               end
            end
            S_READ2: begin
               if (r_reader2_resetn) begin
                  if (io_bus.i_wire_reader_error) begin
                     w_state_next = S_R2_ERR;
                  end else if (io_bus.i_wire_reader_done) begin
                     w_r2_done    = 1'b1;
                     w_state_next = S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               if (r_writer_resetn) begin
                  if (io_bus.i_wire_writer_error) begin
                     w_state_next = S_W_ERR;
                  end else if (io_bus.i_wire_writer_done) begin
                     w_w_done     = 1'b1;
                     w_state_next = S_CALC;
                  end
               end
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   // Datapath: config latch, walk position, burst addresses, enables, FIFO reset pulse.
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         r_mode           <= 1'b0;
         r_src_base       <= '0;
         r_dst_base       <= '0;
         r_src_stride     <= '0;
         r_dst_stride     <= '0;
         r_xcount         <= '0;
         r_ycount         <= '0;
         r_x              <= '0;
         r_y              <= '0;
         r_ys             <= '0;
         r_yd             <= '0;
         r_len            <= '0;
         r_reader_address <= '0;
         r_reader_length  <= '0;
         r_writer_address <= '0;
         r_writer_length  <= '0;
         r_pixels_done    <= '0;
         r_reader1_resetn <= 1'b0;
         r_reader2_resetn <= 1'b0;
         r_writer_resetn  <= 1'b0;
         r_fifo_resetn    <= 1'b0;
         r_fifo_pulse     <= 1'b0;
      end else begin
         // FIFOs are held in reset for one cycle on every start or abort.
         if (io_bus.i_wire_abort || w_start_acc) begin
            r_fifo_resetn <= 1'b0;
            r_fifo_pulse  <= 1'b1;
         end else begin
            r_fifo_pulse <= 1'b0;
            if (r_fifo_pulse) r_fifo_resetn <= 1'b1;
         end
         // An enable rises one cycle after entering its state and falls as soon as the state is left.
         r_reader1_resetn <= (r_state == S_READ1) && (w_state_next == S_READ1);
         r_reader2_resetn <= (r_state == S_READ2) && (w_state_next == S_READ2);
         r_writer_resetn  <= (r_state == S_WRITE) && (w_state_next == S_WRITE);
         if (w_start_acc) begin
            r_mode        <= io_bus.i_wire_mode;
            r_src_base    <= io_bus.i_wire_src_frame_buffer_address;
            r_dst_base    <= io_bus.i_wire_dst_frame_buffer_address;
            r_src_stride  <= io_bus.i_wire_src_frame_buffer_width[CW-1:0];
            r_dst_stride  <= io_bus.i_wire_dst_frame_buffer_width[CW-1:0];
            r_xcount      <= io_bus.i_wire_render_frame_buffer_xcount[CW-1:0];
            r_ycount      <= io_bus.i_wire_render_frame_buffer_ycount[CW-1:0];
            r_x           <= '0;
            r_y           <= '0;
            r_pixels_done <= '0;
         end
         if (w_row_next) begin
            r_x <= '0;
            r_y <= w_y_inc[CW-1:0];
         end
         if (w_calc_offs) begin
            r_ys <= (32'(r_y) * 32'(r_src_stride)) << BPP_LOG2;
            r_yd <= (32'(r_y) * 32'(r_dst_stride)) << BPP_LOG2;
         end
         if (r_state == S_CALC2) begin
            r_len            <= w_len;
            r_reader_address <= r_src_base + r_ys + w_x_off;
            r_reader_length  <= w_len;
         end
         // Destination read (BLEND) uses the destination stride offset.
         if (w_r1_done) r_reader_address <= r_dst_base + r_yd + w_x_off;
         if (w_enter_write) begin
            r_writer_address <= r_dst_base + r_yd + w_x_off;
            r_writer_length  <= r_len;
            r_x              <= r_x + r_len[CW-1:0];
         end
         if (w_w_done) r_pixels_done <= r_pixels_done + r_len;
      end
   end

   assign io_bus.o_wire_reader_address = r_reader_address;
   assign io_bus.o_wire_reader_length  = r_reader_length;
   assign io_bus.o_wire_reader1_resetn = r_reader1_resetn;
   assign io_bus.o_wire_reader2_resetn = r_reader2_resetn;
   assign io_bus.o_wire_writer_address = r_writer_address;
   assign io_bus.o_wire_writer_length  = r_writer_length;
   assign io_bus.o_wire_writer_resetn  = r_writer_resetn;
   assign io_bus.o_wire_fifo1_resetn   = r_fifo_resetn;
   assign io_bus.o_wire_fifo2_resetn   = r_fifo_resetn;
   assign io_bus.o_wire_busy           = (r_state == S_CALC)  || (r_state == S_CALC2) ||
                                         (r_state == S_READ1) || (r_state == S_READ2) ||
                                         (r_state == S_WRITE);
   assign io_bus.o_wire_pixels_done    = r_pixels_done;
   assign io_bus.o_wire_state          = {24'd0, r_state};
endmodule

// File: tb/tb_painterengine_gpu_blit_scheduler.sv
// Bench for the blit scheduler: table of jobs with hand-computed burst lists,
// plus directed sequences for empty rectangles, reader error, abort and reset.
module tb_painterengine_gpu_blit_scheduler;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   painterengine_gpu_blit_scheduler_if bus();

   painterengine_gpu_blit_scheduler #(
      .BLOCK_PIXELS (64),
      .BPP_LOG2     (2),
      .COORD_WIDTH  (16)
   ) dut (
      .i_wire_clock  (clk),
      .i_wire_resetn (rst_n),
      .io_bus        (bus)
   );

   typedef struct {
      logic [1:0]  kind;   // 1 = reader1, 2 = reader2, 3 = writer
      logic [31:0] addr;
      logic [31:0] len;
   } burst_t;

   typedef struct {
      logic        mode;
      logic [31:0] src, dst, sstr, dstr, xc, yc;
      int          first, count;
      logic [31:0] exp_state, exp_pix;
   } job_t;

   burst_t exp_b[29];
   job_t   jobs[6];
   burst_t obs_q[$];

   int  n_checks = 0;
   int  n_errors = 0;
   int  rd_cnt = 0, wr_cnt = 0, n_w = 0;
   bit  prev_r1 = 0, prev_r2 = 0, prev_w = 0, any_en = 0, inject_r2_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic set_b(input int i, input logic [1:0] k, input logic [31:0] a, input logic [31:0] l);
      exp_b[i] = '{k, a, l};
   endtask

   // Burst monitor and reader/writer responder: done two cycles after an enable rises.
   always @(negedge clk) begin
      burst_t b;
      if (bus.o_wire_reader1_resetn && !prev_r1) begin
         b = '{2'd1, bus.o_wire_reader_address, bus.o_wire_reader_length};
         obs_q.push_back(b);
         $display("xfer R1 addr=0x%08h len=%0d", b.addr, b.len);
      end
      if (bus.o_wire_reader2_resetn && !prev_r2) begin
         b = '{2'd2, bus.o_wire_reader_address, bus.o_wire_reader_length};
         obs_q.push_back(b);
         $display("xfer R2 addr=0x%08h len=%0d", b.addr, b.len);
      end
      if (bus.o_wire_writer_resetn && !prev_w) begin
         b = '{2'd3, bus.o_wire_writer_address, bus.o_wire_writer_length};
         obs_q.push_back(b);
         n_w++;
         $display("xfer W  addr=0x%08h len=%0d", b.addr, b.len);
      end
      prev_r1 = bus.o_wire_reader1_resetn;
      prev_r2 = bus.o_wire_reader2_resetn;
      prev_w  = bus.o_wire_writer_resetn;
      if (prev_r1 || prev_r2 || prev_w) any_en = 1'b1;

      bus.i_wire_reader_done  = 1'b0;
      bus.i_wire_reader_error = 1'b0;
      if (prev_r1 || prev_r2) begin
         rd_cnt++;
         if (rd_cnt >= 2) begin
            rd_cnt = 0;
            bus.i_wire_reader_done = 1'b1;
            if (inject_r2_err && prev_r2) bus.i_wire_reader_error = 1'b1;
         end
      end else rd_cnt = 0;

      bus.i_wire_writer_done  = 1'b0;
      bus.i_wire_writer_error = 1'b0;
      if (prev_w) begin
         wr_cnt++;
         if (wr_cnt >= 2) begin
            wr_cnt = 0;
            bus.i_wire_writer_done = 1'b1;
         end
      end else wr_cnt = 0;
   end

   task automatic apply_cfg(input job_t jb);
      bus.i_wire_mode                       = jb.mode;
      bus.i_wire_src_frame_buffer_address   = jb.src;
      bus.i_wire_dst_frame_buffer_address   = jb.dst;
      bus.i_wire_src_frame_buffer_width     = jb.sstr;
      bus.i_wire_dst_frame_buffer_width     = jb.dstr;
      bus.i_wire_render_frame_buffer_xcount = jb.xc;
      bus.i_wire_render_frame_buffer_ycount = jb.yc;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.i_wire_start = 1'b1;
      @(negedge clk);
      bus.i_wire_start = 1'b0;
   endtask

   task automatic wait_not_busy(input string name);
      int cyc = 0;
      while (bus.o_wire_busy === 1'b1 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      chk({name, "_timeout"}, 32'(cyc < 5000), 32'd1);
   endtask

   task automatic run_job(input int j);
      apply_cfg(jobs[j]);
      obs_q.delete();
      pulse_start();
      wait_not_busy($sformatf("job%0d", j));
      chk($sformatf("job%0d_state", j), bus.o_wire_state, jobs[j].exp_state);
      chk($sformatf("job%0d_pixels", j), bus.o_wire_pixels_done, jobs[j].exp_pix);
      chk($sformatf("job%0d_nbursts", j), 32'(obs_q.size()), 32'(jobs[j].count));
      for (int i = 0; i < jobs[j].count; i++) begin
         if (i < obs_q.size()) begin
            chk($sformatf("job%0d_b%0d_kind", j, i), 32'(obs_q[i].kind), 32'(exp_b[jobs[j].first + i].kind));
            chk($sformatf("job%0d_b%0d_addr", j, i), obs_q[i].addr, exp_b[jobs[j].first + i].addr);
            chk($sformatf("job%0d_b%0d_len", j, i), obs_q[i].len, exp_b[jobs[j].first + i].len);
         end
      end
   endtask

   initial begin
      int cyc;
      // mode, src, dst, src stride, dst stride, xcount, ycount, first burst, bursts, state, pixels
      jobs[0] = '{1'b0, 32'h0010_0000, 32'h0020_0000, 32'd256, 32'd256, 32'd130, 32'd2, 0, 12, 32'h06, 32'd260};
      jobs[1] = '{1'b1, 32'h0000_1000, 32'h0000_8000, 32'd10, 32'd20, 32'd3, 32'd1, 12, 3, 32'h06, 32'd3};
      jobs[2] = '{1'b1, 32'h0000_1000, 32'h0000_8000, 32'd10, 32'd20, 32'd3, 32'd2, 15, 6, 32'h06, 32'd6};
      jobs[3] = '{1'b0, 32'h0000_0000, 32'h0000_0100, 32'd100, 32'd100, 32'd65, 32'd1, 21, 4, 32'h06, 32'd65};
      jobs[4] = '{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'd1, 32'd1, 32'd1, 32'd2, 25, 4, 32'h06, 32'd2};
      jobs[5] = '{1'b0, 32'h0000_2000, 32'h0000_3000, 32'd8, 32'd8, 32'd10, 32'd0, 29, 0, 32'h06, 32'd0};
      set_b(0, 1, 32'h0010_0000, 64);  set_b(1, 3, 32'h0020_0000, 64);
      set_b(2, 1, 32'h0010_0100, 64);  set_b(3, 3, 32'h0020_0100, 64);
      set_b(4, 1, 32'h0010_0200, 2);   set_b(5, 3, 32'h0020_0200, 2);
      set_b(6, 1, 32'h0010_0400, 64);  set_b(7, 3, 32'h0020_0400, 64);
      set_b(8, 1, 32'h0010_0500, 64);  set_b(9, 3, 32'h0020_0500, 64);
      set_b(10, 1, 32'h0010_0600, 2);  set_b(11, 3, 32'h0020_0600, 2);
      set_b(12, 1, 32'h0000_1000, 3);  set_b(13, 2, 32'h0000_8000, 3);  set_b(14, 3, 32'h0000_8000, 3);
      set_b(15, 1, 32'h0000_1000, 3);  set_b(16, 2, 32'h0000_8000, 3);  set_b(17, 3, 32'h0000_8000, 3);
      set_b(18, 1, 32'h0000_1028, 3);  set_b(19, 2, 32'h0000_8050, 3);  set_b(20, 3, 32'h0000_8050, 3);
      set_b(21, 1, 32'h0000_0000, 64); set_b(22, 3, 32'h0000_0100, 64);
      set_b(23, 1, 32'h0000_0100, 1);  set_b(24, 3, 32'h0000_0200, 1);
      set_b(25, 1, 32'hFFFF_FFFC, 1);  set_b(26, 3, 32'hFFFF_FFF0, 1);
      set_b(27, 1, 32'h0000_0000, 1);  set_b(28, 3, 32'hFFFF_FFF4, 1);

      bus.i_wire_start = 1'b0;
      bus.i_wire_abort = 1'b0;
      apply_cfg(jobs[0]);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_state", bus.o_wire_state, 32'h0A);
      chk("rst_busy", 32'(bus.o_wire_busy), 0);
      chk("rst_fifo1", 32'(bus.o_wire_fifo1_resetn), 0);
      chk("rst_enables", 32'({bus.o_wire_reader1_resetn, bus.o_wire_reader2_resetn, bus.o_wire_writer_resetn}), 0);
      chk("rst_pixels", bus.o_wire_pixels_done, 0);
      chk("rst_raddr", bus.o_wire_reader_address, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Empty rectangle: xcount = 0 finishes in two cycles with no burst
      begin
         job_t jz = jobs[5];
         jz.xc = 32'd0;
         jz.yc = 32'd5;
         apply_cfg(jz);
      end
      any_en = 1'b0;
      pulse_start();
      chk("x0_calc_state", bus.o_wire_state, 32'h01);
      chk("x0_calc_fifo1", 32'(bus.o_wire_fifo1_resetn), 0);
      chk("x0_calc_fifo2", 32'(bus.o_wire_fifo2_resetn), 0);
      chk("x0_calc_busy", 32'(bus.o_wire_busy), 1);
      @(negedge clk);
      chk("x0_done_state", bus.o_wire_state, 32'h06);
      chk("x0_done_fifo1", 32'(bus.o_wire_fifo1_resetn), 1);
      chk("x0_done_busy", 32'(bus.o_wire_busy), 0);
      repeat (3) @(negedge clk);
      #1;
      chk("x0_no_enable", 32'(any_en), 0);
      chk("x0_done_holds", bus.o_wire_state, 32'h06);

      // Table of jobs
      for (int j = 0; j < 6; j++) run_job(j);

      // Reader error in READ2 (done and error together): error wins
      apply_cfg(jobs[1]);
      obs_q.delete();
      inject_r2_err = 1'b1;
      pulse_start();
      wait_not_busy("r2err");
      chk("r2err_state", bus.o_wire_state, 32'h08);
      chk("r2err_enables", 32'({bus.o_wire_reader1_resetn, bus.o_wire_reader2_resetn, bus.o_wire_writer_resetn}), 0);
      chk("r2err_pixels", bus.o_wire_pixels_done, 0);
      chk("r2err_nbursts", 32'(obs_q.size()), 2);
      repeat (2) @(negedge clk);
      chk("r2err_holds", bus.o_wire_state, 32'h08);
      inject_r2_err = 1'b0;
      run_job(1);

      // Abort during the second write of the 130x2 COPY job
      apply_cfg(jobs[0]);
      obs_q.delete();
      n_w = 0;
      pulse_start();
      cyc = 0;
      while (n_w < 2 && cyc < 5000) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      chk("abort_reach_write", 32'(cyc < 5000), 1);
      chk("abort_pre_state", bus.o_wire_state, 32'h05);
      bus.i_wire_abort = 1'b1;
      @(negedge clk);
      chk("abort_state", bus.o_wire_state, 32'h0A);
      chk("abort_writer_en", 32'(bus.o_wire_writer_resetn), 0);
      chk("abort_fifo1", 32'(bus.o_wire_fifo1_resetn), 0);
      chk("abort_busy", 32'(bus.o_wire_busy), 0);
      chk("abort_pixels", bus.o_wire_pixels_done, 32'd64);
      bus.i_wire_abort = 1'b0;
      @(negedge clk);
      chk("abort_fifo1_release", 32'(bus.o_wire_fifo1_resetn), 1);
      chk("abort_idle_holds", bus.o_wire_state, 32'h0A);

      // Reset in the middle of a job
      apply_cfg(jobs[0]);
      pulse_start();
      cyc = 0;
      while (bus.o_wire_reader1_resetn !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("rstmid_reach_read", 32'(cyc < 100), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rstmid_state", bus.o_wire_state, 32'h0A);
      chk("rstmid_enables", 32'({bus.o_wire_reader1_resetn, bus.o_wire_reader2_resetn, bus.o_wire_writer_resetn}), 0);
      chk("rstmid_raddr", bus.o_wire_reader_address, 0);
      chk("rstmid_rlen", bus.o_wire_reader_length, 0);
      chk("rstmid_fifo", 32'({bus.o_wire_fifo1_resetn, bus.o_wire_fifo2_resetn}), 0);
      chk("rstmid_busy", 32'(bus.o_wire_busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_job(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
